// File: rtl/rx_pkt_filter_dw.sv
// rx_pkt_filter_dw: store-and-forward receive packet filter with width
// down-conversion. Whole packets are buffered, then committed or dropped at EOP.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   din/_vld/_sop/_eop  input words (first byte in MSBs), no backpressure
//   din_mod, din_err    trailing invalid bytes / error, qualified by din_eop
//   dout/_vld/_sop/_eop narrower output beats, valid/ready handshake
//   dout_mod, dout_rdy  trailing invalid bytes on the eop beat / downstream ready
//   pkt_cnt, drop_cnt   saturating forwarded / dropped packet counters
module rx_pkt_filter_dw #(
    parameter int DIN_W   = 32,
    parameter int DOUT_W  = 16,
    parameter int DEPTH   = 64,
    parameter int MIN_LEN = 1,
    parameter int MAX_LEN = 1518,
    parameter int IMOD_W  = $clog2(DIN_W / 8),
    parameter int OMOD_W  = $clog2(DOUT_W / 8)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DIN_W-1:0]  din,
    input  logic              din_vld,
    input  logic              din_sop,
    input  logic              din_eop,
    input  logic [IMOD_W-1:0] din_mod,
    input  logic              din_err,
    output logic [DOUT_W-1:0] dout,
    output logic              dout_vld,
    output logic              dout_sop,
    output logic              dout_eop,
    output logic [OMOD_W-1:0] dout_mod,
    input  logic              dout_rdy,
    output logic [15:0]       pkt_cnt,
    output logic [15:0]       drop_cnt
);

    localparam int R    = DIN_W / DOUT_W;
    localparam int BIN  = DIN_W / 8;
    localparam int BOUT = DOUT_W / 8;
    localparam int AW   = $clog2(DEPTH);
    localparam int PW   = AW + 1;
    localparam int BW   = (R > 1) ? $clog2(R) : 1;
    localparam int EW   = 1 + IMOD_W + DIN_W;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RECV = 1'b1;

    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
    localparam logic [PW-1:0] ONE_P   = PW'(1);
    localparam logic [15:0]   BIN_L   = 16'(BIN);
    localparam logic [15:0]   MIN_L   = 16'(MIN_LEN);
    localparam logic [15:0]   MAX_L   = 16'(MAX_LEN);
    localparam logic [7:0]    BIN_B   = 8'(BIN);
    localparam logic [7:0]    BOUT_B  = 8'(BOUT);
    localparam logic [7:0]    R_B     = 8'(R);

    // Entry format {eop, mod, data}
    logic [EW-1:0] mem_q [DEPTH];

    logic [0:0]        state_q, state_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     commit_q, commit_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [15:0]       len_q, len_d;
    logic              ovf_q, ovf_d;
    logic [15:0]       pkt_q, pkt_d;
    logic [15:0]       drop_q, drop_d;
    logic [BW-1:0]     beat_q, beat_d;
    logic              first_q, first_d;
    logic              vld_q, vld_d;
    logic [DOUT_W-1:0] data_q, data_d;
    logic              sop_q, sop_d;
    logic              eop_q, eop_d;
    logic [OMOD_W-1:0] mod_q, mod_d;

    // Write-side combinational terms
    logic          accept;
    logic          we;
    logic [PW-1:0] base;
    logic [PW-1:0] used;
    logic          full;
    logic [15:0]   cur_len;
    logic          cur_ovf;
    logic [16:0]   len_sum;
    logic [15:0]   nxt_len;
    logic [15:0]   fin_len;
    logic          bad;
    logic [1:0]    drop_inc;
    logic          pkt_inc;
    logic [16:0]   pkt_sum;
    logic [16:0]   drop_sum;

    // Read-side combinational terms
    logic [EW-1:0]     rd_entry;
    logic              r_eop;
    logic [IMOD_W-1:0] r_mod;
    logic [DIN_W-1:0]  r_data;
    logic [DIN_W-1:0]  r_shift;
    logic              avail;
    logic              ld;
    logic [7:0]        vbytes;
    logic [7:0]        nbeats;
    logic [7:0]        lmod;
    logic              last_beat;

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        commit_d = commit_q;
        len_d    = len_q;
        ovf_d    = ovf_q;
        accept   = 1'b0;
        we       = 1'b0;
        base     = wr_ptr_q;
        cur_len  = len_q;
        cur_ovf  = ovf_q;
        drop_inc = 2'd0;
        pkt_inc  = 1'b0;

        if (din_vld) begin
            if (din_sop) begin
                // A sop while receiving abandons the unfinished packet.
                if (state_q == S_RECV) begin
                    base     = commit_q;
                    drop_inc = 2'd1;
                end
                cur_len = 16'd0;
                cur_ovf = 1'b0;
                accept  = 1'b1;
            end else if (state_q == S_RECV) begin
                accept = 1'b1;
            end
        end

        // Words still being sliced out stay counted until fully emitted.
        used    = base - rd_ptr_q;
        full    = (used == DEPTH_P);
        len_sum = {1'b0, cur_len} + {1'b0, BIN_L};
        nxt_len = len_sum[16] ? 16'hFFFF : len_sum[15:0];
        fin_len = nxt_len - 16'(din_mod);
        bad     = din_err | cur_ovf | full
                | (fin_len < MIN_L) | (fin_len > MAX_L);

        if (accept) begin
            we = ~full;
            if (din_eop) begin
                state_d = S_IDLE;
                len_d   = 16'd0;
                ovf_d   = 1'b0;
                if (bad) begin
                    wr_ptr_d = commit_q;
                    drop_inc = drop_inc + 2'd1;
                end else begin
                    wr_ptr_d = base + ONE_P;
                    commit_d = base + ONE_P;
                    pkt_inc  = 1'b1;
                end
            end else begin
                state_d  = S_RECV;
                len_d    = nxt_len;
                ovf_d    = cur_ovf | full;
                wr_ptr_d = full ? base : base + ONE_P;
            end
        end

        pkt_sum  = {1'b0, pkt_q} + 17'(pkt_inc);
        drop_sum = {1'b0, drop_q} + 17'(drop_inc);
        pkt_d    = pkt_sum[16] ? 16'hFFFF : pkt_sum[15:0];
        drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[base[AW-1:0]] <= {din_eop, din_mod, din};
        end
    end

    always_comb begin
        rd_entry = mem_q[rd_ptr_q[AW-1:0]];
        r_eop    = rd_entry[EW-1];
        r_mod    = rd_entry[EW-2 -: IMOD_W];
        r_data   = rd_entry[DIN_W-1:0];
        r_shift  = r_data << (DOUT_W * 32'(beat_q));
        // Reads see only committed words; a same-cycle commit waits a cycle.
        avail    = (rd_ptr_q != commit_q);
        ld       = ~vld_q | dout_rdy;
        vbytes   = BIN_B - 8'(r_mod);
        nbeats   = r_eop ? (vbytes + BOUT_B - 8'd1) / BOUT_B : R_B;
        lmod     = nbeats * BOUT_B - vbytes;
        last_beat = (8'(beat_q) == nbeats - 8'd1);

        rd_ptr_d = rd_ptr_q;
        beat_d   = beat_q;
        first_d  = first_q;
        vld_d    = vld_q;
        data_d   = data_q;
        sop_d    = sop_q;
        eop_d    = eop_q;
        mod_d    = mod_q;

        if (ld) begin
            if (avail) begin
                vld_d   = 1'b1;
                data_d  = r_shift[DIN_W-1 -: DOUT_W];
                sop_d   = first_q;
                eop_d   = r_eop & last_beat;
                mod_d   = (r_eop & last_beat) ? lmod[OMOD_W-1:0] : '0;
                first_d = r_eop & last_beat;
                if (last_beat) begin
                    rd_ptr_d = rd_ptr_q + ONE_P;
                    beat_d   = '0;
                end else begin
                    beat_d = beat_q + BW'(1);
                end
            end else begin
                vld_d  = 1'b0;
                data_d = '0;
                sop_d  = 1'b0;
                eop_d  = 1'b0;
                mod_d  = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            commit_q <= '0;
            rd_ptr_q <= '0;
            len_q    <= '0;
            ovf_q    <= 1'b0;
            pkt_q    <= '0;
            drop_q   <= '0;
            beat_q   <= '0;
            first_q  <= 1'b1;
            vld_q    <= 1'b0;
            data_q   <= '0;
            sop_q    <= 1'b0;
            eop_q    <= 1'b0;
            mod_q    <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            commit_q <= commit_d;
            rd_ptr_q <= rd_ptr_d;
            len_q    <= len_d;
            ovf_q    <= ovf_d;
            pkt_q    <= pkt_d;
            drop_q   <= drop_d;
            beat_q   <= beat_d;
            first_q  <= first_d;
            vld_q    <= vld_d;
            data_q   <= data_d;
            sop_q    <= sop_d;
            eop_q    <= eop_d;
            mod_q    <= mod_d;
        end
    end

    assign dout     = data_q;
    assign dout_vld = vld_q;
    assign dout_sop = sop_q;
    assign dout_eop = eop_q;
    assign dout_mod = mod_q;
    assign pkt_cnt  = pkt_q;
    assign drop_cnt = drop_q;

endmodule
